// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_if
//  Purpose  : SPI slave front end; deserialises MOSI command words and shifts
//             RAM read bytes out on MISO. Option macro: SPI_TX_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_slave_if #(
    parameter int RX_W       = 10,
    parameter int TX_W       = 8,
    parameter int TX_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            SS_n,
    input  logic            MOSI,
    output logic            MISO,
    output logic [RX_W-1:0] rx_data,
    output logic            rx_valid,
    input  logic [TX_W-1:0] tx_data,
    input  logic            tx_valid
`ifdef SPI_TX_TIMEOUT_EN
    ,
    output logic            tx_timeout
`endif
);

    localparam int CNT_W = $clog2(RX_W);
    localparam int TXC_W = $clog2(TX_W);

    if (TX_TIMEOUT < 1 || RX_W < 3 || TX_W < 3) begin : g_param_check
        $error("spi_slave_if: unsupported parameter values");
    end

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHK_CMD   = 3'd1,
        ST_WRITE     = 3'd2,
        ST_READ_ADD  = 3'd3,
        ST_READ_DATA = 3'd4
    } state_t;

    // Sub-phase of the three frame states: receive word, await RAM byte,
    // shift it out, then idle until SS_n releases the frame.
    typedef enum logic [1:0] {
        PH_RX       = 2'd0,
        PH_WAIT_TX  = 2'd1,
        PH_SHIFT_TX = 2'd2,
        PH_DONE     = 2'd3
    } phase_t;

    state_t            r_state;
    phase_t            r_phase;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [RX_W-2:0]   r_rx_shift;
    logic [TXC_W-1:0]  r_tx_cnt;
    logic [TX_W-2:0]   r_tx_shift;
    logic              r_rd_addr_seen;
`ifdef SPI_TX_TIMEOUT_EN
    localparam int TO_W = $clog2(TX_TIMEOUT + 1);
    logic [TO_W-1:0]   r_to_cnt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_phase        <= PH_RX;
            r_bit_cnt      <= '0;
            r_rx_shift     <= '0;
            r_tx_cnt       <= '0;
            r_tx_shift     <= '0;
            r_rd_addr_seen <= 1'b0;
            MISO           <= 1'b0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
`ifdef SPI_TX_TIMEOUT_EN
            r_to_cnt       <= '0;
            tx_timeout     <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
`ifdef SPI_TX_TIMEOUT_EN
            tx_timeout <= 1'b0;
`endif
            if (r_state != ST_IDLE && SS_n) begin
                // Frame released or aborted; a partial word is dropped and
                // rd_addr_seen is left as it was.
                r_state   <= ST_IDLE;
                r_phase   <= PH_RX;
                r_bit_cnt <= '0;
                r_tx_cnt  <= '0;
                MISO      <= 1'b0;
`ifdef SPI_TX_TIMEOUT_EN
                r_to_cnt  <= '0;
`endif
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_phase   <= PH_RX;
                        r_bit_cnt <= '0;
                        MISO      <= 1'b0;
                        if (!SS_n) begin
                            r_state <= ST_CHK_CMD;
                        end
                    end
                    ST_CHK_CMD: begin
                        if (!MOSI) begin
                            r_state <= ST_WRITE;
                        end else if (r_rd_addr_seen) begin
                            r_state <= ST_READ_DATA;
                        end else begin
                            r_state <= ST_READ_ADD;
                        end
                    end
                    default: begin
                        case (r_phase)
                            PH_RX: begin
                                r_rx_shift <= {r_rx_shift[RX_W-3:0], MOSI};
                                if (r_bit_cnt == CNT_W'(RX_W - 1)) begin
                                    rx_data   <= {r_rx_shift, MOSI};
                                    rx_valid  <= 1'b1;
                                    r_bit_cnt <= '0;
                                    if (r_state == ST_READ_ADD) begin
                                        r_rd_addr_seen <= 1'b1;
                                    end
                                    if (r_state == ST_READ_DATA) begin
                                        r_phase <= PH_WAIT_TX;
                                    end else begin
                                        r_phase <= PH_DONE;
                                    end
`ifdef SPI_TX_TIMEOUT_EN
                                    r_to_cnt <= '0;
`endif
                                end else begin
                                    r_bit_cnt <= r_bit_cnt + 1'b1;
                                end
                            end
                            PH_WAIT_TX: begin
                                if (tx_valid) begin
                                    MISO       <= tx_data[TX_W-1];
                                    r_tx_shift <= tx_data[TX_W-2:0];
                                    r_tx_cnt   <= TXC_W'(TX_W - 1);
                                    r_phase    <= PH_SHIFT_TX;
                                end
`ifdef SPI_TX_TIMEOUT_EN
                                else if (r_to_cnt == TO_W'(TX_TIMEOUT - 1)) begin
                                    tx_timeout     <= 1'b1;
                                    r_rd_addr_seen <= 1'b0;
                                    r_to_cnt       <= '0;
                                    r_phase        <= PH_DONE;
                                end else begin
                                    r_to_cnt <= r_to_cnt + 1'b1;
                                end
`endif
                            end
                            PH_SHIFT_TX: begin
                                if (r_tx_cnt != '0) begin
                                    MISO       <= r_tx_shift[TX_W-2];
                                    r_tx_shift <= {r_tx_shift[TX_W-3:0], 1'b0};
                                    r_tx_cnt   <= r_tx_cnt - 1'b1;
                                end else begin
                                    // Bit 0 has had its cycle on the wire.
                                    MISO           <= 1'b0;
                                    r_rd_addr_seen <= 1'b0;
                                    r_phase        <= PH_DONE;
                                end
                            end
                            default: begin
                                MISO <= 1'b0;
                            end
                        endcase
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_if.sv
`default_nettype none
`timescale 1ns/1ps
// Self-checking bench for spi_slave_if: table of command frames plus
// hand-written read, abort, reset and timeout sequences.
module tb_spi_slave_if;

    localparam int RX_W = 10;
    localparam int TX_W = 8;
    localparam int TX_TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            SS_n = 1'b1;
    logic            MOSI = 1'b0;
    logic            MISO;
    logic [RX_W-1:0] rx_data;
    logic            rx_valid;
    logic [TX_W-1:0] tx_data = '0;
    logic            tx_valid = 1'b0;
`ifdef SPI_TX_TIMEOUT_EN
    logic            tx_timeout;
`endif

    spi_slave_if #(.RX_W(RX_W), .TX_W(TX_W), .TX_TIMEOUT(TX_TIMEOUT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
`ifdef SPI_TX_TIMEOUT_EN
        ,
        .tx_timeout (tx_timeout)
`endif
    );

    typedef struct {
        logic [RX_W-1:0] word;
        int              at;
    } exp_t;

    typedef struct {
        logic            dir;
        logic [RX_W-1:0] word;
        logic            txv;
        logic            seen;
    } vec_t;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   miso_hi_cnt = 0;
    exp_t sb[$];
    exp_t rx_log[$];
    int   to_log[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (MISO === 1'b1) miso_hi_cnt <= miso_hi_cnt + 1;
        if (rx_valid === 1'b1) rx_log.push_back('{rx_data, cyc});
`ifdef SPI_TX_TIMEOUT_EN
        if (tx_timeout === 1'b1) to_log.push_back(cyc);
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives n_low sampled edges with SS_n low: IDLE edge, direction bit,
    // then word bits MSB first. A full frame (12) is pushed to the scoreboard.
    task automatic send_frame(input logic dir, input logic [RX_W-1:0] w, input int n_low);
        logic [RX_W-1:0] wv;
        int k;
        wv = w;
        k = cyc;
        if (n_low == 12) sb.push_back('{w, k + 12});
        for (int n = 0; n < n_low; n++) begin
            SS_n = 1'b0;
            if (n == 0) MOSI = 1'b0;
            else if (n == 1) MOSI = dir;
            else MOSI = wv[RX_W + 1 - n];
            tick();
        end
        MOSI = 1'b0;
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick();
    endtask

    task automatic drain();
        exp_t g;
        exp_t e;
        while (rx_log.size() > 0) begin
            g = rx_log.pop_front();
            if (sb.size() == 0) begin
                check("rx_unexpected", {22'd0, g.word}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("rx_data", {22'd0, g.word}, {22'd0, e.word});
                check("rx_latency", g.at, e.at);
            end
        end
    endtask

    initial begin
        vec_t vecs[6];
        logic [TX_W-1:0] txb;
        int mh;
        int rc;
        int r;

        vecs[0] = '{1'b0, 10'h0A5, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 10'h13C, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 10'h2A5, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 10'h155, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 10'h3FF, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 10'h2C7, 1'b0, 1'b1};

        // Reset state
        tick(); tick(); tick();
        check("reset_miso", {31'd0, MISO}, 32'd0);
        check("reset_rx_data", {22'd0, rx_data}, 32'd0);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_seen", {31'd0, dut.r_rd_addr_seen}, 32'd0);
        check("reset_state", 32'(dut.r_state), 32'd0);
        check("reset_bit_cnt", 32'(dut.r_bit_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // Table of command frames; tx_valid/tx_data=FF held where txv set
        for (int i = 0; i < 6; i++) begin
            mh = miso_hi_cnt;
            tx_data = 8'hFF;
            tx_valid = vecs[i].txv;
            send_frame(vecs[i].dir, vecs[i].word, 12);
            end_frame();
            tx_valid = 1'b0;
            tick();
            drain();
            check($sformatf("seen_vec%0d", i), {31'd0, dut.r_rd_addr_seen}, {31'd0, vecs[i].seen});
            check($sformatf("miso_quiet_vec%0d", i), miso_hi_cnt - mh, 0);
        end

        // SS_n rises in the cycle the 10th bit would be sampled
        rc = sb.size();
        send_frame(1'b0, 10'h3C3, 11);
        end_frame();
        tick();
        drain();
        check("late_abort_no_rx", sb.size(), rc);
        check("rx_data_hold", {22'd0, rx_data}, {22'd0, 10'h2C7});

        // Abort a READ_DATA frame after 6 data bits; seen stays set
        send_frame(1'b1, 10'h155, 8);
        end_frame();
        check("abort_rd_state", 32'(dut.r_state), 32'd0);
        check("abort_rd_seen", {31'd0, dut.r_rd_addr_seen}, 32'd1);
        tick();
        drain();
        send_frame(1'b0, 10'h0F0, 12);
        end_frame();
        drain();

        // Read data: response C3 two cycles after rx_valid
        txb = 8'hC3;
        send_frame(1'b1, 10'h300, 12);
        tick(); tick();
        tx_valid = 1'b1;
        tx_data = txb;
        tick();
        tx_valid = 1'b0;
        tx_data = 8'h00;
        for (int b = 0; b < 8; b++) begin
            check($sformatf("miso_bit%0d", 7 - b), {31'd0, MISO}, {31'd0, txb[7 - b]});
            tick();
        end
        check("miso_after_tx", {31'd0, MISO}, 32'd0);
        check("seen_after_tx", {31'd0, dut.r_rd_addr_seen}, 32'd0);
        end_frame();
        drain();

        // Abort READ_ADD after 6 bits with seen clear; seen stays clear
        send_frame(1'b1, 10'h2AA, 8);
        end_frame();
        check("abort_ra_state", 32'(dut.r_state), 32'd0);
        check("abort_ra_seen", {31'd0, dut.r_rd_addr_seen}, 32'd0);

        // Next read frame must decode as READ_ADD
        send_frame(1'b1, 10'h2A5, 12);
        check("next_read_is_addr", 32'(dut.r_state), 32'd3);
        end_frame();
        drain();
        check("seen_after_ra", {31'd0, dut.r_rd_addr_seen}, 32'd1);

        // Reset while MISO carries bit 3 of 0F
        txb = 8'h0F;
        send_frame(1'b1, 10'h3AA, 12);
        tick();
        tx_valid = 1'b1;
        tx_data = txb;
        tick();
        tx_valid = 1'b0;
        tick(); tick(); tick(); tick();
        check("miso_bit3_pre_rst", {31'd0, MISO}, {31'd0, txb[3]});
        rst_n = 1'b0;
        tick();
        check("rst_tx_miso", {31'd0, MISO}, 32'd0);
        check("rst_tx_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_tx_seen", {31'd0, dut.r_rd_addr_seen}, 32'd0);
        check("rst_tx_state", 32'(dut.r_state), 32'd0);
        rst_n = 1'b1;
        SS_n = 1'b1;
        tick();
        drain();

`ifdef SPI_TX_TIMEOUT_EN
        // No response: single tx_timeout pulse 16 cycles after rx_valid
        send_frame(1'b1, 10'h2A5, 12);
        end_frame();
        drain();
        mh = miso_hi_cnt;
        send_frame(1'b1, 10'h311, 12);
        r = cyc;
        for (int n = 0; n < 24; n++) tick();
        check("timeout_pulses", to_log.size(), 1);
        if (to_log.size() > 0) check("timeout_at", to_log[0] - r, TX_TIMEOUT);
        check("timeout_miso", miso_hi_cnt - mh, 0);
        check("timeout_seen", {31'd0, dut.r_rd_addr_seen}, 32'd0);
        end_frame();
        drain();
`else
        r = 0;
`endif

        check("scoreboard_empty", sb.size() + r * 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- Serial-to-parallel front end between an external SPI master and the single-port RAM command stage.
- Deserialises MOSI frames into 10-bit command words {cmd[1:0], payload[7:0]} and presents each word with a one-cycle rx_valid strobe.
- For read-data frames, accepts the RAM's 8-bit response (tx_data/tx_valid) and serialises it MSB-first on MISO.
- All sampling is on clk, with SS_n, MOSI and MISO treated as synchronous to clk (one SPI bit per clk).

Parameters:
- RX_W, 10, width of the command word sent downstream.
- TX_W, 8, width of the response byte shifted out on MISO.
- TX_TIMEOUT, 16, cycles to wait for tx_valid. Used only with SPI_TX_TIMEOUT_EN.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- SS_n  input  1  slave select, active-low; high aborts/ends a frame.
- MOSI  input  1  serial data from master, MSB first.
- MISO  output  1  serial data to master, MSB first.
- rx_data  output  RX_W  assembled command word.
- rx_valid  output  1  one-cycle strobe, rx_data valid.
- tx_data  input  TX_W  read byte from RAM stage.
- tx_valid  input  1  tx_data valid strobe.
- tx_timeout  output  1  one-cycle timeout strobe. Present only with SPI_TX_TIMEOUT_EN.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, MISO=0, rx_data=0, rx_valid=0, bit counter=0, rd_addr_seen=0, tx_timeout=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 -> CHK_CMD next cycle; otherwise stay.
- CHK_CMD: MOSI sampled as direction bit; it is not stored.
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_seen=0 -> READ_ADD.
  - MOSI=1 and rd_addr_seen=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA receive phase:
  - Each cycle with SS_n=0 shifts MOSI into the shift register LSB and increments the counter; first bit lands in bit 9.
  - After the 10th bit: rx_data loads the word and rx_valid=1 for exactly the next cycle, then 0.
  - Further MOSI bits are ignored.
- READ_ADD: rd_addr_seen is set in the cycle rx_valid asserts.
- READ_DATA transmit phase:
  - After rx_valid, wait for tx_valid=1; tx_data is captured in that cycle.
  - MISO drives tx_data[7] on the following cycle, then bits 6..0 on the next 7 cycles.
  - After bit 0, MISO returns to 0 and rd_addr_seen clears.
- tx_valid is ignored in every state except READ_DATA-awaiting-response.
- MISO is 0 whenever not transmitting.
- SS_n=1 in any non-IDLE state -> IDLE next cycle and counters clear.
  - A partial receive produces no rx_valid.
  - An aborted READ_ADD leaves rd_addr_seen unchanged.
  - An aborted READ_DATA (before bit 0 is sent) keeps rd_addr_seen=1.
- SS_n rising in the same cycle the 10th bit is sampled: that bit is not taken and the frame is aborted. A 10th bit sampled with SS_n=0 always yields rx_valid on the next cycle, even if SS_n rises then.
- rx_data holds its last value between strobes.
- Latency: SS_n falling-edge sample to rx_valid = 12 cycles (1 IDLE + 1 CHK_CMD + 10 bits).

Optional Feature:
- Macro: SPI_TX_TIMEOUT_EN.
- Defined:
  - In READ_DATA-awaiting-response, a counter runs. If TX_TIMEOUT cycles elapse without tx_valid, tx_timeout pulses for 1 cycle.
  - rd_addr_seen clears, MISO stays 0, and the FSM waits for SS_n=1.
  - The tx_timeout port exists.
- Undefined: waits indefinitely for tx_valid; no tx_timeout port and no counter logic.

Test Plan:
- Write address: SS_n=0, MOSI 0 then 00_1010_0101 -> rx_data=10'h0A5, rx_valid high for 1 cycle 12 cycles after SS_n fall; MISO stays 0.
- Write data then read address: frames 0+01_0011_1100 and 1+10_1010_0101 -> rx_data=10'h13C, then 10'h2A5; rd_addr_seen=1 after the second frame.
- Read data: frame 1+11_0000_0000, tx_valid with tx_data=8'hC3 two cycles after rx_valid -> MISO 1,1,0,0,0,0,1,1 on 8 consecutive cycles; the next read frame goes to READ_ADD.
- Abort: SS_n high after 6 data bits -> no rx_valid, state IDLE next cycle, rd_addr_seen unchanged; a following full frame decodes correctly.
- Reset mid-transmit: rst_n=0 during MISO bit 3 -> MISO=0, rx_valid=0, rd_addr_seen=0 next cycle.
- With SPI_TX_TIMEOUT_EN: read-data frame, no tx_valid -> tx_timeout pulse exactly 16 cycles after rx_valid, MISO=0, rd_addr_seen=0.
